// File: rtl/rc4_init.sv
// RC4 key-schedule initialiser: writes S[i] = i for every i in 0..2^ADDR_W-1, one write per clock.
// Optional RC4_INIT_DONE_EN adds a one-cycle 'done' pulse in the first idle cycle after a completed pass.
module rc4_init #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              rdy,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] wrdata,
    output logic              wren
`ifdef RC4_INIT_DONE_EN
    ,
    output logic              done
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    state_t            state_q;
    logic [ADDR_W-1:0] i_q;
    logic [ADDR_W-1:0] i_d;
    logic              rdy_q;
    logic              wren_q;
`ifdef RC4_INIT_DONE_EN
    logic              done_q;
`endif

    assign i_d = i_q + 1'b1;

    // i_q is held at zero while idle, so the address/data outputs come straight from it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            i_q     <= '0;
            rdy_q   <= 1'b1;
            wren_q  <= 1'b0;
`ifdef RC4_INIT_DONE_EN
            done_q  <= 1'b0;
`endif
        end else begin
`ifdef RC4_INIT_DONE_EN
            done_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (en) begin
                        state_q <= WRITE;
                        i_q     <= '0;
                        rdy_q   <= 1'b0;
                        wren_q  <= 1'b1;
                    end
                end
                WRITE: begin
                    if (i_q == LAST_IDX) begin
                        state_q <= IDLE;
                        i_q     <= '0;
                        rdy_q   <= 1'b1;
                        wren_q  <= 1'b0;
`ifdef RC4_INIT_DONE_EN
                        done_q  <= 1'b1;
`endif
                    end else begin
                        i_q <= i_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    i_q     <= '0;
                    rdy_q   <= 1'b1;
                    wren_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rdy    = rdy_q;
    assign wren   = wren_q;
    assign addr   = i_q;
    assign wrdata = i_q;
`ifdef RC4_INIT_DONE_EN
    assign done   = done_q;
`endif

endmodule

// File: tb/tb_rc4_init.sv
// Randomised scoreboard bench for rc4_init: a queue-based model of the write pass predicts
// every cycle's outputs; a monitor on the falling edge pops and compares them.
module tb_rc4_init;

    localparam int ADDR_W = 8;
    localparam int N      = 1 << ADDR_W;

    logic              clk;
    logic              rst;
    logic              en;
    logic              rdy;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] wrdata;
    logic              wren;
    logic              done_w;

    rc4_init #(.ADDR_W(ADDR_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .rdy    (rdy),
        .addr   (addr),
        .wrdata (wrdata),
        .wren   (wren)
`ifdef RC4_INIT_DONE_EN
        ,
        .done   (done_w)
`endif
    );

`ifndef RC4_INIT_DONE_EN
    assign done_w = 1'b0;
`endif

    typedef struct packed {
        logic              rdy;
        logic              wren;
        logic [ADDR_W-1:0] addr;
        logic              done;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   stim_done = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a pass is a list of outstanding write addresses.
    int pending[$];
    bit writing = 0;
    int cur     = 0;
    bit done_m  = 0;

    always @(posedge clk) begin
        exp_t e;
        if (rst) begin
            pending.delete();
            writing = 0;
            cur     = 0;
            done_m  = 0;
        end else if (writing) begin
            done_m = 0;
            if (pending.size() == 0) begin
                writing = 0;
                cur     = 0;
                done_m  = 1;
            end else begin
                cur = pending.pop_front();
            end
        end else begin
            done_m = 0;
            if (en) begin
                for (int k = 1; k < N; k++) pending.push_back(k);
                writing = 1;
                cur     = 0;
            end
        end
        e.rdy  = !writing;
        e.wren = writing;
        e.addr = cur[ADDR_W-1:0];
`ifdef RC4_INIT_DONE_EN
        e.done = done_m;
`else
        e.done = 1'b0;
`endif
        exp_q.push_back(e);
    end

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
        end
    endtask

    task automatic check_vec(input string name, input logic [ADDR_W-1:0] act,
                             input logic [ADDR_W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    // Monitor: outputs are presented every cycle, so one expectation is consumed per falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_bit("rdy",    rdy,    e.rdy);
            check_bit("wren",   wren,   e.wren);
            check_vec("addr",   addr,   e.addr);
            check_vec("wrdata", wrdata, e.addr);
            check_bit("done",   done_w, e.done);
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        cycle();
        en = 1'b0;
        cycle();
        rst = 1'b0;
        repeat (4) cycle();

        // Clean single pass with en pulsed for one cycle.
        en = 1'b1;
        cycle();
        en = 1'b0;
        repeat (N + 4) cycle();

        // en toggles randomly during writes and around pass boundaries.
        en = 1'b1;
        cycle();
        repeat (2 * N + 50) begin
            en = 1'($urandom_range(0, 1));
            cycle();
        end
        en = 1'b0;
        repeat (N + 4) cycle();

        // Abort at address 100, with en asserted alongside reset.
        en = 1'b1;
        cycle();
        en = 1'b0;
        repeat (100) cycle();
        rst = 1'b1;
        en  = 1'b1;
        cycle();
        rst = 1'b0;
        en  = 1'b0;
        repeat (4) cycle();

        // en held high: back-to-back passes with a single idle cycle between.
        en = 1'b1;
        repeat (3 * (N + 1) + 5) cycle();
        en = 1'b0;
        repeat (N + 4) cycle();

        // Random resets mixed with random enables.
        repeat (3 * N) begin
            rst = ($urandom_range(0, 99) < 2);
            en  = 1'($urandom_range(0, 1));
            cycle();
        end
        rst = 1'b0;
        en  = 1'b0;
        repeat (N + 4) cycle();

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end
        stim_done = 1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        if (!stim_done) begin
            $display("FAIL watchdog: got timeout expected completion");
            $fatal(1, "watchdog expired");
        end
    end

endmodule
